pal_sync_gen: RTL and testbench

- Video timing generator sitting directly upstream of the VPU pixel pipeline.
- Produces the horizontal and vertical pixel counters, the vertical blanking flag and the horizontal sync pulse that the VPU uses for window gating, line and address reload and the shifter.
- Produces the PAL-style composite sync, including equalizing and broad pulses, that drives tvout[0].
- Timing is 312-line progressive at 512 pixel clocks per line (8 MHz pixel clock, 64 us per line).

---
 rtl/vpu_timing_pkg.sv | 20 ++
 rtl/sync_pulse_shaper.sv | 27 ++
 rtl/pal_sync_gen.sv | 111 +++++++++++
 tb/tb_pal_sync_gen.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vpu_timing_pkg.sv
// rtl/vpu_timing_pkg.sv - shared PAL video timing types and default constants
package vpu_timing_pkg;

  typedef enum logic [1:0] {
    LT_BROAD,
    LT_POST_EQ,
    LT_NORMAL,
    LT_PRE_EQ
  } line_type_e;

  localparam int unsigned CNT_W        = 9;
  localparam int unsigned H_TOTAL      = 512;
  localparam int unsigned V_TOTAL      = 312;
  localparam int unsigned HSYNC_LEN    = 38;
  localparam int unsigned EQ_LEN       = 19;
  localparam int unsigned BROAD_LEN    = 218;
  localparam int unsigned VBL_LINES    = 25;
  localparam int unsigned PRE_EQ_FIRST = 310;

endpackage

// File: rtl/sync_pulse_shaper.sv
// rtl/sync_pulse_shaper.sv - next composite sync level from line type and next cntHS
module sync_pulse_shaper
  import vpu_timing_pkg::*;
#(
  parameter int unsigned HSYNC_LEN = vpu_timing_pkg::HSYNC_LEN,
  parameter int unsigned EQ_LEN    = vpu_timing_pkg::EQ_LEN,
  parameter int unsigned BROAD_LEN = vpu_timing_pkg::BROAD_LEN
) (
  input  line_type_e       line_type_i,
  input  logic [CNT_W-1:0] cnt_hs_i,
  output logic             sync_o
);

  // Equalizing and broad pulses repeat every half line.
  logic [7:0] half_pos;
  assign half_pos = cnt_hs_i[7:0];

  always_comb begin
    sync_o = 1'b1;
    case (line_type_i)
      LT_NORMAL: sync_o = (cnt_hs_i >= CNT_W'(HSYNC_LEN));
      LT_BROAD:  sync_o = (half_pos >= 8'(BROAD_LEN));
      default:   sync_o = (half_pos >= 8'(EQ_LEN));
    endcase
  end

endmodule

// File: rtl/pal_sync_gen.sv
// rtl/pal_sync_gen.sv - 312-line PAL timing generator: counters, line-type FSM, registered syncs
module pal_sync_gen
  import vpu_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL      = vpu_timing_pkg::H_TOTAL,
  parameter int unsigned V_TOTAL      = vpu_timing_pkg::V_TOTAL,
  parameter int unsigned HSYNC_LEN    = vpu_timing_pkg::HSYNC_LEN,
  parameter int unsigned EQ_LEN       = vpu_timing_pkg::EQ_LEN,
  parameter int unsigned BROAD_LEN    = vpu_timing_pkg::BROAD_LEN,
  parameter int unsigned VBL_LINES    = vpu_timing_pkg::VBL_LINES,
  parameter int unsigned PRE_EQ_FIRST = vpu_timing_pkg::PRE_EQ_FIRST
) (
  input  logic             pixel_clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [CNT_W-1:0] cntHS,
  output logic [CNT_W-1:0] cntVS,
  output logic             vbl,
  output logic             hsync,
  output logic             out_sync,
  output logic             frame_start
);

  if (BROAD_LEN >= 256) begin : g_bad_broad
    $fatal(1, "BROAD_LEN must be shorter than half a line");
  end
  if (EQ_LEN >= HSYNC_LEN) begin : g_bad_eq
    $fatal(1, "EQ_LEN must be shorter than HSYNC_LEN");
  end
  if (VBL_LINES > V_TOTAL) begin : g_bad_vbl
    $fatal(1, "VBL_LINES must not exceed V_TOTAL");
  end
  if (PRE_EQ_FIRST <= 5) begin : g_bad_pre_eq
    $fatal(1, "PRE_EQ_FIRST must follow the post-equalizing lines");
  end

  localparam logic [CNT_W-1:0] LINE_POST_EQ = CNT_W'(3);
  localparam logic [CNT_W-1:0] LINE_NORMAL  = CNT_W'(6);
  localparam logic [CNT_W-1:0] LINE_PRE_EQ  = CNT_W'(PRE_EQ_FIRST);

  logic [CNT_W-1:0] hs_q, hs_d, vs_q, vs_d;
  line_type_e       lt_q, lt_d;
  logic             vbl_q, vbl_d, hsync_q, hsync_d;
  logic             sync_q, sync_d, fs_q, fs_d;
  logic             line_end;

  assign line_end = (hs_q == CNT_W'(H_TOTAL - 1));

  // Outputs are derived from the next counter values so they line up with the counters.
  always_comb begin
    hs_d = hs_q;
    vs_d = vs_q;
    lt_d = lt_q;
    if (en) begin
      if (line_end) begin
        hs_d = '0;
        vs_d = (vs_q == CNT_W'(V_TOTAL - 1)) ? '0 : vs_q + 1'b1;
        case (lt_q)
          LT_BROAD:   if (vs_d == LINE_POST_EQ) lt_d = LT_POST_EQ;
          LT_POST_EQ: if (vs_d == LINE_NORMAL)  lt_d = LT_NORMAL;
          LT_NORMAL:  if (vs_d == LINE_PRE_EQ)  lt_d = LT_PRE_EQ;
          LT_PRE_EQ:  if (vs_d == '0)           lt_d = LT_BROAD;
          default:    lt_d = LT_BROAD;
        endcase
      end else begin
        hs_d = hs_q + 1'b1;
      end
    end
    vbl_d   = ({1'b0, vs_d} < (CNT_W + 1)'(VBL_LINES));
    hsync_d = (hs_d < CNT_W'(HSYNC_LEN));
    fs_d    = (hs_d == '0) && (vs_d == '0);
  end

  sync_pulse_shaper #(
    .HSYNC_LEN (HSYNC_LEN),
    .EQ_LEN    (EQ_LEN),
    .BROAD_LEN (BROAD_LEN)
  ) u_shaper (
    .line_type_i (lt_d),
    .cnt_hs_i    (hs_d),
    .sync_o      (sync_d)
  );

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q    <= '0;
      vs_q    <= '0;
      lt_q    <= LT_BROAD;
      vbl_q   <= 1'b1;
      hsync_q <= 1'b1;
      sync_q  <= 1'b0;
      fs_q    <= 1'b1;
    end else begin
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      lt_q    <= lt_d;
      vbl_q   <= vbl_d;
      hsync_q <= hsync_d;
      sync_q  <= sync_d;
      fs_q    <= fs_d;
    end
  end

  assign cntHS       = hs_q;
  assign cntVS       = vs_q;
  assign vbl         = vbl_q;
  assign hsync       = hsync_q;
  assign out_sync    = sync_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_pal_sync_gen.sv
// tb/tb_pal_sync_gen.sv - self-checking bench for pal_sync_gen on a shortened 104-line frame
module tb_pal_sync_gen;

  localparam int HT   = 512;
  localparam int VT   = 104;
  localparam int PRE  = 102;
  localparam int HSL  = 38;
  localparam int EQL  = 19;
  localparam int BRL  = 218;
  localparam int VBLL = 25;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [8:0] cnt_hs, cnt_vs;
  logic       vbl, hsync, out_sync, frame_start;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int   hs;
    int   vs;
    logic vbl;
    logic hsync;
    logic sync;
    logic fs;
  } exp_t;

  typedef struct {
    int   vs;
    int   hs;
    logic sync;
    logic vbl;
    logic hsync;
  } vec_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   m_hs, m_vs;
  int   fs_cnt, vbl_hi, vbl_lo, hs_hi;

  pal_sync_gen #(
    .V_TOTAL      (VT),
    .PRE_EQ_FIRST (PRE)
  ) dut (
    .pixel_clk   (clk),
    .rst_n       (rst_n),
    .en          (en),
    .cntHS       (cnt_hs),
    .cntVS       (cnt_vs),
    .vbl         (vbl),
    .hsync       (hsync),
    .out_sync    (out_sync),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(int hs, int vs);
    exp_t e;
    int   h;
    h       = hs % 256;
    e.hs    = hs;
    e.vs    = vs;
    e.vbl   = (vs < VBLL);
    e.hsync = (hs < HSL);
    e.fs    = (hs == 0) && (vs == 0);
    if (vs <= 2)                e.sync = (h >= BRL);
    else if (vs <= 5 || vs >= PRE) e.sync = (h >= EQL);
    else                        e.sync = (hs >= HSL);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      total++;
      if (cnt_hs !== 9'(e.hs) || cnt_vs !== 9'(e.vs) || vbl !== e.vbl ||
          hsync !== e.hsync || out_sync !== e.sync || frame_start !== e.fs) begin
        bad++;
        $display("FAIL cycle: got hs=%0d vs=%0d vbl=%b hsync=%b sync=%b fs=%b want hs=%0d vs=%0d vbl=%b hsync=%b sync=%b fs=%b",
                 cnt_hs, cnt_vs, vbl, hsync, out_sync, frame_start,
                 e.hs, e.vs, e.vbl, e.hsync, e.sync, e.fs);
      end
    end
  end

  // Called one time unit after a falling edge; returns at the same phase one cycle later.
  task automatic tick(input logic e);
    en = e;
    if (e && rst_n) begin
      if (m_hs == HT - 1) begin
        m_hs = 0;
        m_vs = (m_vs == VT - 1) ? 0 : m_vs + 1;
      end else begin
        m_hs++;
      end
    end
    sb.push_back(model(m_hs, m_vs));
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic add(input int vs, input int hs, input logic s, input logic v, input logic h);
    tbl.push_back('{vs, hs, s, v, h});
  endtask

  task automatic observe();
    if (frame_start) fs_cnt++;
    if (cnt_hs == 0) begin
      if (vbl) vbl_hi++;
      else     vbl_lo++;
    end
    if (cnt_vs == 0 && hsync) hs_hi++;
  endtask

  initial begin
    int n;
    int idx;
    bit resume;

    rst_n = 1'b0;
    en    = 1'b0;
    // {line, pixel, out_sync, vbl, hsync}, ascending through the frame
    add(1, 217, 0, 1, 0);   add(1, 218, 1, 1, 0);   add(1, 256, 0, 1, 0);
    add(1, 473, 0, 1, 0);   add(1, 474, 1, 1, 0);   add(2, 300, 0, 1, 0);
    add(3, 18, 0, 1, 1);    add(3, 100, 1, 1, 0);   add(4, 18, 0, 1, 1);
    add(4, 19, 1, 1, 1);    add(4, 256, 0, 1, 0);   add(4, 274, 0, 1, 0);
    add(4, 275, 1, 1, 0);   add(5, 300, 1, 1, 0);   add(6, 10, 0, 1, 1);
    add(6, 260, 1, 1, 0);   add(24, 100, 1, 1, 0);  add(25, 0, 0, 0, 1);
    add(100, 37, 0, 0, 1);  add(100, 38, 1, 0, 0);  add(100, 256, 1, 0, 0);
    add(101, 300, 1, 0, 0); add(102, 256, 0, 0, 0); add(102, 275, 1, 0, 0);
    add(103, 18, 0, 0, 1);  add(103, 19, 1, 0, 1);  add(103, 274, 0, 0, 0);
    add(103, 511, 1, 0, 0);

    @(negedge clk);
    #1;
    chk("rst_hs", cnt_hs, 0);
    chk("rst_vs", cnt_vs, 0);
    chk("rst_vbl", vbl, 1);
    chk("rst_hsync", hsync, 1);
    chk("rst_sync", out_sync, 0);
    chk("rst_fs", frame_start, 1);

    rst_n = 1'b1;
    m_hs  = 0;
    m_vs  = 0;
    tick(1'b0);
    fs_cnt = 0; vbl_hi = 0; vbl_lo = 0; hs_hi = 0;
    observe();

    n = 0;
    idx = 0;
    resume = 1'b0;
    while (n < 60000) begin
      tick(1'b1);
      n++;
      if (resume) begin
        chk("resume_hs", cnt_hs, 201);
        resume = 1'b0;
      end
      if (n == HT) begin
        chk("line0_wrap_hs", cnt_hs, 0);
        chk("line0_wrap_vs", cnt_vs, 1);
      end
      if (cnt_hs == 0 && cnt_vs == 0) break;
      observe();
      if (idx < tbl.size() && m_vs == tbl[idx].vs && m_hs == tbl[idx].hs) begin
        chk($sformatf("tbl%0d_sync", idx), out_sync, tbl[idx].sync);
        chk($sformatf("tbl%0d_vbl", idx), vbl, tbl[idx].vbl);
        chk($sformatf("tbl%0d_hsync", idx), hsync, tbl[idx].hsync);
        idx++;
      end
      if (m_vs == 50 && m_hs == 200) begin
        repeat (7) tick(1'b0);
        chk("hold_hs", cnt_hs, 200);
        chk("hold_vs", cnt_vs, 50);
        resume = 1'b1;
      end
    end
    chk("frame_clocks", n, VT * HT);
    chk("frame_start_at_wrap", frame_start, 1);
    chk("frame_start_count", fs_cnt, 1);
    chk("vbl_lines_high", vbl_hi, VBLL);
    chk("vbl_lines_low", vbl_lo, VT - VBLL);
    chk("hsync_line0_cycles", hs_hi, HSL);
    chk("table_hits", idx, tbl.size());

    for (int i = 0; i < 3 * HT + 300; i++) tick(1'b1);
    chk("pre_reset_sync", out_sync, 1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_hs", cnt_hs, 0);
    chk("async_rst_vs", cnt_vs, 0);
    chk("async_rst_sync", out_sync, 0);
    chk("async_rst_vbl", vbl, 1);
    chk("async_rst_fs", frame_start, 1);
    @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    m_hs  = 0;
    m_vs  = 0;
    repeat (3) tick(1'b1);
    chk("restart_hs", cnt_hs, 3);
    chk("restart_vs", cnt_vs, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
